// File: rtl/freq_meter_bcd.sv
// -----------------------------------------------------------------------------
// freq_meter_bcd
//
// Gated frequency counter with a 4-digit BCD result. Rising edges of sig_i are
// counted over a window of GATE_CYCLES clocks in four cascaded decade counters.
// At the end of each window the count is latched onto bcd_o/ovf_o together with
// a one-cycle valid_o strobe. The window then restarts while enable_i stays high.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk_i cycles (2 .. 2**GATE_W-1)
//   GATE_W       width of the gate counter
//
// Ports:
//   clk_i     in   system clock
//   reset     in   asynchronous active-low reset
//   sig_i     in   signal under measurement, asynchronous to clk_i
//   enable_i  in   measurement enable; dropping it mid-window discards the count
//   bcd_o     out  latched count, [15:12] thousands .. [3:0] units
//   valid_o   out  one-cycle strobe in the cycle bcd_o/ovf_o take a new value
//   ovf_o     out  latched: the last window counted past 9999
//   busy_o    out  high while a window is in progress (GATE or LATCH)
//
// Build option:
//   FREQ_METER_SATURATE_EN  defined   -> on overflow the digits freeze at 9999
//                           undefined -> the digits wrap modulo 10000
//   In both builds ovf_o reports that the window overflowed.
// -----------------------------------------------------------------------------
module freq_meter_bcd #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned GATE_W      = 26
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        sig_i,
    input  logic        enable_i,
    output logic [15:0] bcd_o,
    output logic        valid_o,
    output logic        ovf_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

    // ------------------------------------------------------------------
    // Input conditioning: two flops for metastability, a third flop to
    // detect the rising edge on the synchronized signal.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic edge_pulse;

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_pulse = sync2_q & ~sync3_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [GATE_W-1:0] gate_q,     gate_d;
    // dig_q[3] is thousands, dig_q[0] is units, so the packed vector is
    // already in bcd_o layout.
    logic [3:0][3:0]   dig_q,      dig_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [15:0]       bcd_q,      bcd_d;
    logic              ovf_q,      ovf_d;
    logic              valid_q,    valid_d;

    // ------------------------------------------------------------------
    // Decade cascade: +1 on the units digit, rippling through the digits
    // in the same cycle. all_nines is the carry out of thousands, which
    // is set exactly when the current count is 9999.
    // ------------------------------------------------------------------
    logic [3:0][3:0] dig_inc;
    logic            carry;
    logic            all_nines;

    always_comb begin
        dig_inc = dig_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (dig_q[i] == 4'd9) begin
                    dig_inc[i] = 4'd0;
                    carry      = 1'b1;
                end else begin
                    dig_inc[i] = dig_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        dig_d      = dig_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                gate_d     = '0;
                dig_d      = '0;
                ovf_flag_d = 1'b0;
                if (enable_i) begin
                    state_d = GATE;
                end
            end

            GATE: begin
                if (edge_pulse) begin
`ifdef FREQ_METER_SATURATE_EN
                    // Once the count has reached 9999 and overflowed, the
                    // digits stay at 9999 for the rest of the window.
                    if (!ovf_flag_q) begin
                        if (all_nines) begin
                            ovf_flag_d = 1'b1;
                        end else begin
                            dig_d = dig_inc;
                        end
                    end
`else
                    dig_d = dig_inc;
                    if (all_nines) begin
                        ovf_flag_d = 1'b1;
                    end
`endif
                end

                if (!enable_i) begin
                    // Abort: throw away the partial count, outputs untouched.
                    state_d    = IDLE;
                    gate_d     = '0;
                    dig_d      = '0;
                    ovf_flag_d = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // Latch the count including an edge in this final gate
                    // cycle, so the result and the strobe appear together
                    // during the LATCH cycle.
                    state_d = LATCH;
                    gate_d  = '0;
                    bcd_d   = dig_d;
                    ovf_d   = ovf_flag_d;
                    valid_d = 1'b1;
                end else begin
                    gate_d = gate_q + GATE_ONE;
                end
            end

            LATCH: begin
                // Dead cycle: edges are ignored while the counters clear.
                gate_d     = '0;
                dig_d      = '0;
                ovf_flag_d = 1'b0;
                state_d    = enable_i ? GATE : IDLE;
            end

            default: begin
                state_d    = IDLE;
                gate_d     = '0;
                dig_d      = '0;
                ovf_flag_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            dig_q      <= '0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            dig_q      <= dig_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == GATE) || (state_q == LATCH);

endmodule

// File: doc/freq_meter_bcd.md
# freq_meter_bcd

- Measures the frequency of an external or divided square wave.
- Counts rising edges over a fixed gate window of `GATE_CYCLES` clocks, using four cascaded 0–9 BCD digit counters.
- Latches the result as a 4-digit BCD word with a one-cycle valid strobe.
- Sits on the receiving end of the decade-divider frequency generators: it reads back the generated frequencies for display on the 7-segment path and for self-check.

## Interface
Parameters:
- `GATE_CYCLES`, 50_000_000, gate window length in `clk_i` cycles (1 s at 50 MHz); legal range 2..2^`GATE_W`−1.
- `GATE_W`, 26, width of the gate counter.

Ports:
- `clk_i`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sig_i`  in  1  signal under measurement, asynchronous to `clk_i`.
- `enable_i`  in  1  measurement enable, synchronous.
- `bcd_o`  out  16  latched count; [15:12] thousands … [3:0] units.
- `valid_o`  out  1  one-cycle strobe when `bcd_o`/`ovf_o` update.
- `ovf_o`  out  1  latched: count exceeded 9999 in the last window.
- `busy_o`  out  1  high while state is GATE or LATCH.

## Operation
Input conditioning:
- `sig_i` passes through a 2-FF synchronizer, then a third register.
- Edge pulse = sync2 & ~sync3.
- Input high and low phases must each be ≥2 `clk_i` periods to be counted reliably.

State machine, states IDLE, GATE, LATCH:
- IDLE: digits and gate counter held at 0. `enable_i`=1 → GATE on the next cycle.
- GATE: gate counter increments from 0 each cycle.
  - An edge pulse in any GATE cycle increments the units digit.
  - When the gate counter equals `GATE_CYCLES`−1 → LATCH.
  - `enable_i`=0 in any GATE cycle → IDLE next cycle. The partial count is discarded, with no `valid_o` and no output change.
- LATCH (exactly 1 cycle):
  - `bcd_o` ← digits and `ovf_o` ← overflow flag; `valid_o`=1.
  - Digits, overflow flag and gate counter clear.
  - Edges in this cycle are not counted (one-cycle dead time).
  - Next state is GATE if `enable_i`=1, else IDLE.

Digit rules:
- Each digit counts 0..9. On 9 plus increment it returns to 0 and carries into the next digit in the same cycle.
- A carry out of thousands when the count is 9999 sets the internal overflow flag; the wrap/saturate behaviour is set by the Configuration macro.

Other rules:
- `enable_i` changes during LATCH affect only the next-state choice.
- `bcd_o` and `ovf_o` hold their value between windows and through IDLE.

## Timing
- Reset (`reset`=0, asynchronous): `bcd_o`=16'h0000, `valid_o`=0, `ovf_o`=0, `busy_o`=0, state IDLE, synchronizer regs 0, digits 0.
- Reset deassertion is used synchronously.
- Reset mid-window aborts with no strobe.
- Latency from a `sig_i` rising edge to the digit increment is 3–4 clocks, so edges in the last 3 gate cycles may fall into the next window.
- Window period is `GATE_CYCLES`+1 clocks: GATE for `GATE_CYCLES` cycles plus 1 LATCH cycle.
- First `valid_o` comes `GATE_CYCLES`+1 cycles after the first cycle `enable_i`=1 is sampled in IDLE.
- `valid_o` is high for exactly 1 cycle, in the cycle `bcd_o` takes its new value.
- `busy_o` rises the cycle after `enable_i` is sampled high in IDLE.

## Configuration
`FREQ_METER_SATURATE_EN`:
- Defined: on overflow all digits freeze at 9999 for the rest of the window, so `bcd_o` reads 16'h9999 with `ovf_o`=1.
- Undefined: digits wrap modulo 10000 and `ovf_o`=1 still flags the wrap.

## Test plan
- Reset: hold `reset`=0 with `sig_i` toggling → `bcd_o`=0x0000, `valid_o`=0, `ovf_o`=0, `busy_o`=0; release → still idle until `enable_i`=1.
- `GATE_CYCLES`=100, `sig_i` period 10 clk (5 high/5 low), `enable_i`=1 → first `valid_o` at cycle 101 after enable; every window `bcd_o`=0x0010, `ovf_o`=0.
- `GATE_CYCLES`=100, period 4 clk → `bcd_o`=0x0025 each window, checking the units→tens carry at 9→0.
- `GATE_CYCLES`=50000, period 4 clk → 12500 edges:
  - with `FREQ_METER_SATURATE_EN`: `bcd_o`=0x9999, `ovf_o`=1;
  - without it: `bcd_o`=0x2500, `ovf_o`=1;
  - next window at period 10 clk → 0x5000, `ovf_o`=0.
- Abort: `GATE_CYCLES`=100, drop `enable_i` at gate cycle 50 → no `valid_o`, `bcd_o` keeps its prior value, `busy_o`=0 next cycle; re-enable → full fresh window result 0x0010 at period 10.
- Async reset asserted mid-GATE → all outputs 0 within the same cycle, state IDLE, no `valid_o` after release until a new full window completes.
